// File: rtl/regfile_writeback_queue.sv
// Register-file write-back queue.
// Buffers register-write results and retires them in arrival order through the
// single regfile write port, one write per cycle. Two snoop ports forward the
// youngest pending value for a register so readers never see stale data.
module regfile_writeback_queue #(
  parameter int width = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [width-1:0]         in_data,
  input  logic                     wb_hold,
  output logic [4:0]               W_addr,
  output logic [width-1:0]         W_data,
  output logic                     wr_enable,
  input  logic [4:0]               A_addr,
  input  logic [4:0]               B_addr,
  output logic                     A_fwd_hit,
  output logic [width-1:0]         A_fwd_data,
  output logic                     B_fwd_hit,
  output logic [width-1:0]         B_fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Entry payload and bookkeeping
  logic [4:0]       addr_mem [DEPTH];
  logic [width-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic accept;
  logic enq;
  logic deq;

  // Status flags come straight from the registered count
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign in_ready = !full;

  // Writes to $zero complete the handshake but are dropped here
  assign accept    = in_valid && in_ready;
  assign enq       = accept && (in_addr != 5'd0);
  assign wr_enable = !empty && !wb_hold;
  assign deq       = wr_enable;

  // Regfile port is driven from the head entry's storage, zero when idle
  assign W_addr = empty ? 5'd0 : addr_mem[head_q];
  assign W_data = empty ? '0 : data_mem[head_q];

  // Payload storage: written at the tail on every enqueue
  // NOTE: the payload arrays are deliberately not reset; the valid bits and
  // count already mark every slot as dead after reset, and leaving memories
  // out of the reset tree lets them map onto plain storage.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[tail_q] <= in_addr;
      data_mem[tail_q] <= in_data;
    end
  end

  // Pointer, count and valid-bit state; reset discards all pending writes
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (deq) begin
        head_q          <= head_q + PTR_W'(1);
        valid_q[head_q] <= 1'b0;
      end
      if (enq) begin
        tail_q          <= tail_q + PTR_W'(1);
        valid_q[tail_q] <= 1'b1;
      end
      count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Snoop both read addresses; scanning oldest to youngest lets the youngest
  // match overwrite older ones, which preserves same-register write ordering
  // NOTE: every output of this block gets a default first so no latch is
  // inferred when no entry matches.
  always_comb begin
    A_fwd_hit  = 1'b0;
    A_fwd_data = '0;
    B_fwd_hit  = 1'b0;
    B_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[head_q + PTR_W'(i)] && (A_addr != 5'd0) &&
          (addr_mem[head_q + PTR_W'(i)] == A_addr)) begin
        A_fwd_hit  = 1'b1;
        A_fwd_data = data_mem[head_q + PTR_W'(i)];
      end
      if (valid_q[head_q + PTR_W'(i)] && (B_addr != 5'd0) &&
          (addr_mem[head_q + PTR_W'(i)] == B_addr)) begin
        B_fwd_hit  = 1'b1;
        B_fwd_data = data_mem[head_q + PTR_W'(i)];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed self-checking bench for regfile_writeback_queue.
module tb_regfile_writeback_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_addr;
  logic [WIDTH-1:0]  in_data;
  logic              wb_hold;
  logic [4:0]        W_addr;
  logic [WIDTH-1:0]  W_data;
  logic              wr_enable;
  logic [4:0]        A_addr;
  logic [4:0]        B_addr;
  logic              A_fwd_hit;
  logic [WIDTH-1:0]  A_fwd_data;
  logic              B_fwd_hit;
  logic [WIDTH-1:0]  B_fwd_data;
  logic [2:0]        count;
  logic              empty;
  logic              full;

  int pass_cnt = 0;
  int total_cnt = 0;

  regfile_writeback_queue #(.width(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wb_hold(wb_hold),
    .W_addr(W_addr), .W_data(W_data), .wr_enable(wr_enable),
    .A_addr(A_addr), .B_addr(B_addr),
    .A_fwd_hit(A_fwd_hit), .A_fwd_data(A_fwd_data),
    .B_fwd_hit(B_fwd_hit), .B_fwd_data(B_fwd_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    wb_hold = 1'b0; A_addr = '0; B_addr = '0;

    // ---- reset state
    #12;
    check("rst_wr_enable", wr_enable, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_W_addr", W_addr, 0);
    check("rst_W_data", W_data, 0);
    check("rst_A_hit", A_fwd_hit, 0);
    tick();
    reset = 1'b1;
    tick();

    // ---- single write, one-cycle latency
    push(5'd5, 32'hDEAD_BEEF);
    check("t1_wr_enable", wr_enable, 1);
    check("t1_W_addr", W_addr, 5);
    check("t1_W_data", W_data, 32'hDEAD_BEEF);
    check("t1_count", count, 1);
    tick();
    check("t1_empty_after", empty, 1);
    check("t1_wr_enable_after", wr_enable, 0);

    // ---- fill under hold, 5th write waits, then ordered drain
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h11 * i);
    in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h99;
    #1;
    check("t2_full", full, 1);
    check("t2_in_ready", in_ready, 0);
    check("t2_count", count, 4);
    check("t2_held_wr_enable", wr_enable, 0);
    wb_hold = 1'b0;
    #1;
    check("t2_d1_wr_enable", wr_enable, 1);
    check("t2_d1_W_addr", W_addr, 1);
    check("t2_d1_W_data", W_data, 32'h11);
    tick();  // r1 retires, 5th not yet accepted (queue was full)
    check("t2_d2_W_addr", W_addr, 2);
    check("t2_d2_W_data", W_data, 32'h22);
    check("t2_d2_count", count, 3);
    check("t2_d2_in_ready", in_ready, 1);
    tick();  // r2 retires, r9 accepted
    in_valid = 1'b0;
    check("t2_d3_W_addr", W_addr, 3);
    check("t2_d3_count", count, 3);
    tick();
    check("t2_d4_W_addr", W_addr, 4);
    check("t2_d4_W_data", W_data, 32'h44);
    tick();
    check("t2_d5_W_addr", W_addr, 9);
    check("t2_d5_W_data", W_data, 32'h99);
    check("t2_d5_count", count, 1);
    tick();
    check("t2_empty", empty, 1);

    // ---- forwarding: youngest match wins
    wb_hold = 1'b1;
    push(5'd7, 32'h1);
    push(5'd3, 32'h33);
    push(5'd7, 32'h2);
    A_addr = 5'd7; B_addr = 5'd3;
    #1;
    check("t3_A_hit", A_fwd_hit, 1);
    check("t3_A_data", A_fwd_data, 32'h2);
    check("t3_B_hit", B_fwd_hit, 1);
    check("t3_B_data", B_fwd_data, 32'h33);
    B_addr = 5'd4;
    #1;
    check("t3_B_miss_hit", B_fwd_hit, 0);
    check("t3_B_miss_data", B_fwd_data, 0);
    B_addr = 5'd3;
    wb_hold = 1'b0;
    tick();  // first r7 retires
    wb_hold = 1'b1;
    #1;
    check("t3_dr1_A_data", A_fwd_data, 32'h2);
    check("t3_dr1_count", count, 2);
    wb_hold = 1'b0;
    #1;
    check("t3_head_pending_B_hit", B_fwd_hit, 1);
    check("t3_head_pending_B_data", B_fwd_data, 32'h33);
    tick();  // r3 retires
    check("t3_dr2_B_hit", B_fwd_hit, 0);
    check("t3_dr2_A_hit", A_fwd_hit, 1);
    tick();  // last r7 retires
    check("t3_dr3_A_hit", A_fwd_hit, 0);
    check("t3_dr3_A_data", A_fwd_data, 0);

    // ---- $zero filter
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFF;
    #1;
    check("t4_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t4_count", count, 0);
    check("t4_wr_enable", wr_enable, 0);
    A_addr = 5'd0;
    #1;
    check("t4_A_hit", A_fwd_hit, 0);
    tick();
    check("t4_wr_enable_later", wr_enable, 0);

    // ---- continuous accept + drain, pointers wrap
    for (int k = 0; k <= 3 * DEPTH; k++) begin
      if (k < 3 * DEPTH) begin
        in_valid = 1'b1;
        in_addr  = 5'(k + 1);
        in_data  = 32'h100 + k;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k > 0) begin
        check($sformatf("t5_%0d_wr_enable", k), wr_enable, 1);
        check($sformatf("t5_%0d_W_addr", k), W_addr, k);
        check($sformatf("t5_%0d_W_data", k), W_data, 32'h100 + k - 1);
        check($sformatf("t5_%0d_count", k), count, 1);
      end
      tick();
    end
    check("t5_empty", empty, 1);

    // ---- reset mid-operation discards pending writes
    wb_hold = 1'b1;
    push(5'd10, 32'hA0);
    push(5'd11, 32'hB0);
    push(5'd12, 32'hC0);
    A_addr = 5'd10;
    wb_hold = 1'b0;
    #1;
    check("t6_pre_count", count, 3);
    check("t6_pre_wr_enable", wr_enable, 1);
    check("t6_pre_A_hit", A_fwd_hit, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_wr_enable", wr_enable, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_A_hit", A_fwd_hit, 0);
    check("t6_rst_W_addr", W_addr, 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t6_post_%0d_wr_enable", k), wr_enable, 0);
    end
    check("t6_post_empty", empty, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
